// File: rtl/mask_enc_pkg.sv
// mask_enc_pkg: shared widths, FSM state type and helpers for mask_encoder.
//
// Contents:
//   MASK_W  - width of the request mask (8)
//   IDX_W   - width of a binary bit index (3)
//   CNT_W   - width of a popcount of a full mask, 0..8 (4)
//   state_t - encoder FSM states (IDLE, SCAN)
//   popcount() - number of set bits in a mask, used by the optional
//                out_cnt feature (macro MASK_ENC_COUNT_EN)
package mask_enc_pkg;

  localparam int MASK_W = 8;
  localparam int IDX_W  = 3;
  localparam int CNT_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Counts set bits of a mask; a full 8-bit mask gives 8, which is why
  // the result needs one bit more than an index.
  function automatic logic [CNT_W-1:0] popcount(input logic [MASK_W-1:0] m);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < MASK_W; i++) begin
      c = c + CNT_W'(m[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/mask_encoder_lsb_pri_enc.sv
// lsb_pri_enc: combinational lowest-set-bit priority encoder.
//
// Ports:
//   vec     (in,  MASK_W) - bit vector to search
//   idx     (out, IDX_W)  - index of the lowest set bit, 0 when vec is zero
//   nonzero (out, 1)      - at least one bit of vec is set
module lsb_pri_enc
  import mask_enc_pkg::*;
(
  input  logic [MASK_W-1:0] vec,
  output logic [IDX_W-1:0]  idx,
  output logic              nonzero
);

  // Scan from the top bit downwards so the last hit, i.e. the lowest set
  // bit, wins; an all-zero vector leaves the default index of 0.
  always_comb begin
    idx = '0;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

  assign nonzero = |vec;

endmodule

// File: rtl/mask_encoder.sv
// mask_encoder: turns an accepted 8-bit request mask into a stream of
// binary indices, one beat per set bit, lowest index first.
//
// Ports:
//   clk         (in)     - rising-edge clock for all state
//   rst_n       (in)     - asynchronous active-low reset
//   in_valid    (in)     - upstream offers in_mask
//   in_ready    (out)    - block is idle and can take a mask
//   in_mask     (in, 8)  - bit i set means index i is requested
//   out_valid   (out)    - out_idx/out_last carry a beat
//   out_ready   (in)     - downstream consumes the beat
//   out_idx     (out, 3) - index of the current set bit
//   out_last    (out)    - current beat is the final set bit of the mask
//   empty_pulse (out)    - one-cycle flag: an all-zero mask was consumed
//   out_cnt     (out, 4) - popcount of the accepted mask; present only when
//                          macro MASK_ENC_COUNT_EN is defined
module mask_encoder
  import mask_enc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MASK_W-1:0] in_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              empty_pulse
`ifdef MASK_ENC_COUNT_EN
  ,
  output logic [CNT_W-1:0]  out_cnt
`endif
);

  state_t            state;
  state_t            state_next;
  logic [MASK_W-1:0] pend;
  logic [MASK_W-1:0] pend_next;
  logic              alive;
  logic              accept;
  logic              pend_nonzero;

  // The lowest pending bit is always the beat on offer.
  lsb_pri_enc u_lsb_pri_enc (
    .vec     (pend),
    .idx     (out_idx),
    .nonzero (pend_nonzero)
  );

  // pend & (pend - 1) drops the lowest set bit; if nothing is left the
  // current beat is the last one.
  assign out_last  = pend_nonzero && ((pend & (pend - MASK_W'(1))) == '0);
  assign out_valid = (state == SCAN);
  // alive keeps in_ready low while reset is held even though the state
  // register already sits in IDLE.
  assign in_ready  = alive && (state == IDLE);
  assign accept    = in_valid && in_ready;

  // Next-state logic: load a non-zero mask from IDLE, clear one bit per
  // handshake in SCAN and fall back to IDLE on the last beat. A zero mask
  // leaves the FSM in IDLE; only empty_pulse reacts to it.
  always_comb begin
    state_next = state;
    pend_next  = pend;
    unique case (state)
      IDLE: begin
        if (accept && (in_mask != '0)) begin
          pend_next  = in_mask;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (out_ready) begin
          pend_next = pend & ~(MASK_W'(1) << out_idx);
          if (out_last) begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        pend_next  = '0;
      end
    endcase
  end

  // State and pending-bit registers. Reset drops any partly scanned mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pend        <= '0;
      alive       <= 1'b0;
      empty_pulse <= 1'b0;
    end else begin
      state       <= state_next;
      pend        <= pend_next;
      alive       <= 1'b1;
      empty_pulse <= accept && (in_mask == '0);
    end
  end

`ifdef MASK_ENC_COUNT_EN
  // Popcount is captured only at acceptance, which can only happen in
  // IDLE, so it stays constant for the whole scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt <= '0;
    end else if (accept) begin
      out_cnt <= popcount(in_mask);
    end
  end
`endif

endmodule

// File: tb/tb_mask_encoder.sv
// tb_mask_encoder: self-checking bench for mask_encoder. Expected beats are
// pushed to a scoreboard queue when a mask is accepted and compared as the
// DUT offers them. Define MASK_ENC_COUNT_EN to also check out_cnt.
module tb_mask_encoder;

  typedef struct packed {
    logic [2:0] idx;
    logic       last;
  } beat_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_mask;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic       out_last;
  logic       empty_pulse;
`ifdef MASK_ENC_COUNT_EN
  logic [3:0] out_cnt;
  logic [3:0] exp_cnt;
`endif

  beat_t sb[$];
  int    checks;
  int    errors;
  int    beat_cnt;

  mask_encoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_mask     (in_mask),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_idx     (out_idx),
    .out_last    (out_last),
    .empty_pulse (empty_pulse)
`ifdef MASK_ENC_COUNT_EN
    ,
    .out_cnt     (out_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: on every falling edge compare the offered beat with the head
  // of the scoreboard; pop it when the handshake will complete on the next
  // rising edge, otherwise it must stay on offer unchanged.
  always @(negedge clk) begin
    if (out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_beat: got idx=%0d last=%0b, required no beat", out_idx, out_last);
      end else begin
        if (out_idx !== sb[0].idx || out_last !== sb[0].last) begin
          errors++;
          $display("[TB] FAIL beat: got idx=%0d last=%0b, required idx=%0d last=%0b",
                   out_idx, out_last, sb[0].idx, sb[0].last);
        end
`ifdef MASK_ENC_COUNT_EN
        checks++;
        if (out_cnt !== exp_cnt) begin
          errors++;
          $display("[TB] FAIL out_cnt: got %0d, required %0d", out_cnt, exp_cnt);
        end
`endif
        if (out_ready) begin
          void'(sb.pop_front());
          beat_cnt++;
        end
      end
    end
  end

  // Offers a mask and holds it until accepted; expected beats go to the
  // scoreboard at acceptance. Returns #1 after the accepting edge.
  task automatic send_mask(input logic [7:0] m);
    bit done;
    int hi;
    done = 0;
    in_mask  = m;
    in_valid = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        hi = -1;
        for (int i = 0; i < 8; i++) if (m[i]) hi = i;
        for (int i = 0; i < 8; i++) begin
          if (m[i]) sb.push_back('{idx: 3'(i), last: (i == hi)});
        end
`ifdef MASK_ENC_COUNT_EN
        exp_cnt = 4'($countones(m));
`endif
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    in_valid = 1'b0;
    in_mask  = 8'h5A;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 for 50 cycles, required acceptance");
    end
  endtask

  // Waits until every expected beat was seen and the block is idle again.
  task automatic wait_drain();
    bit done;
    done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && in_ready) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL drain: got %0d beats outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mask   = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, out_idx, out_last, empty_pulse} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got rdy=%0b vld=%0b idx=%0d last=%0b empty=%0b, required all 0",
               in_ready, out_valid, out_idx, out_last, empty_pulse);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_reset: got %0b, required 1", in_ready);
    end
  endtask

  task automatic test_burst();
    out_ready = 1'b1;
    send_mask(8'b1010_0100);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL first_beat_latency: got out_valid=%0b, required 1", out_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL last_beat_cycle: got rdy=%0b vld=%0b, required rdy=0 vld=1", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL burst_end: got rdy=%0b vld=%0b left=%0d, required rdy=1 vld=0 left=0",
               in_ready, out_valid, sb.size());
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    send_mask(8'h80);
    repeat (3) @(posedge clk);
    #1;
    beat_cnt  = 0;
    out_ready = 1'b1;
    wait_drain();
    checks++;
    if (beat_cnt != 1) begin
      errors++;
      $display("[TB] FAIL stall_beats: got %0d, required 1", beat_cnt);
    end
  endtask

  task automatic test_empty();
    out_ready = 1'b1;
    send_mask(8'h00);
    checks++;
    if (empty_pulse !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL empty_accept: got empty=%0b vld=%0b rdy=%0b, required 1 0 1",
               empty_pulse, out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (empty_pulse !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL empty_after: got empty=%0b vld=%0b rdy=%0b, required 0 0 1",
               empty_pulse, out_valid, in_ready);
    end
  endtask

  task automatic test_toggle();
    bit done;
    done      = 0;
    beat_cnt  = 0;
    out_ready = 1'b1;
    send_mask(8'hFF);
    for (int c = 0; c < 60 && !done; c++) begin
      out_ready = ~out_ready;
      @(posedge clk);
      #1;
      if (sb.size() == 0 && in_ready) done = 1;
    end
    checks++;
    if (!done || beat_cnt != 8) begin
      errors++;
      $display("[TB] FAIL toggle_handshakes: got %0d, required 8", beat_cnt);
      sb.delete();
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send_mask(8'h0F);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_scan: got vld=%0b rdy=%0b, required 0 0", out_valid, in_ready);
    end
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_mid_reset: got %0b, required 1", in_ready);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stale_beat: got out_valid=%0b, required 0", out_valid);
    end
  endtask

  task automatic test_ignore();
    out_ready = 1'b0;
    send_mask(8'h06);
    in_valid = 1'b1;
    in_mask  = 8'hF0;
    repeat (2) @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send_mask(8'h11);
    send_mask(8'h42);
    send_mask(8'h01);
    wait_drain();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    beat_cnt = 0;
    test_reset();
    test_burst();
    test_stall();
    test_empty();
    test_toggle();
    test_reset_mid();
    test_ignore();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mask_encoder.md
MASK_ENCODER -- requirements
Module: mask_encoder

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Port clk SHALL be input, width 1: rising-edge clock for all state.
REQ-003 Port rst_n SHALL be input, width 1: asynchronous active-low reset.
REQ-004 Port in_valid SHALL be input, width 1: upstream mask offered.
REQ-005 Port in_ready SHALL be output, width 1: block can accept a mask.
REQ-006 Port in_mask SHALL be input, width 8: bit vector, bit i set means index i is requested.
REQ-007 Port out_valid SHALL be output, width 1: out_idx/out_last valid.
REQ-008 Port out_ready SHALL be input, width 1: downstream consumes the beat.
REQ-009 Port out_idx SHALL be output, width 3: binary index of the current set bit.
REQ-010 Port out_last SHALL be output, width 1: current beat is the final set bit of the mask.
REQ-011 Port empty_pulse SHALL be output, width 1: one-cycle flag that an all-zero mask was consumed.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE and SCAN.
REQ-013 In IDLE: in_ready=1 and out_valid=0; in SCAN: in_ready=0 and out_valid=1.
REQ-014 A mask SHALL be accepted on a rising edge with in_valid&&in_ready; a non-zero mask SHALL be loaded into register pend and the FSM SHALL move to SCAN.
REQ-015 On acceptance of in_mask==8'h00: the FSM SHALL stay in IDLE, no output beat SHALL be produced, and empty_pulse SHALL be 1 for exactly the next cycle.
REQ-016 In SCAN: out_idx SHALL equal the lowest set bit of pend, and out_last SHALL be 1 iff pend has exactly one bit set.
REQ-017 On out_valid&&out_ready: the bit at out_idx SHALL be cleared in pend; if out_last=1, the FSM SHALL go to IDLE.
REQ-018 While out_valid=1 and out_ready=0, out_idx and out_last SHALL hold stable.
REQ-019 The first beat SHALL appear in the cycle after acceptance (latency 1); under continuous out_ready, a k-bit mask SHALL give k back-to-back beats in ascending index order.
REQ-020 A new mask SHALL NOT be accepted in the cycle of the last handshake; in_ready SHALL rise the cycle after, so the minimum period is k+1 cycles.
REQ-021 in_mask SHALL be ignored outside the acceptance edge.

Reset
REQ-022 While rst_n=0: state=IDLE, pend=0, out_valid=0, out_idx=0, out_last=0, empty_pulse=0, in_ready=0.
REQ-023 in_ready SHALL become 1 in the first cycle after rst_n deasserts.
REQ-024 Reset during SCAN SHALL discard all remaining pend bits without emitting further beats.

Configuration
REQ-025 When macro MASK_ENC_COUNT_EN is defined, a 4-bit output out_cnt SHALL carry the popcount (0..8) of the accepted mask; it SHALL be registered at acceptance, held constant through SCAN, and reset to 0.
REQ-026 Without MASK_ENC_COUNT_EN, the out_cnt port and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-027 Package mask_enc_pkg SHALL hold MASK_W=8, IDX_W=3, CNT_W=4 and the state enum type (IDLE, SCAN).
REQ-028 The lowest-set-bit search SHALL be a combinational sub-module lsb_pri_enc (8-bit in, 3-bit index plus a nonzero flag out), instantiated once on pend.

Verification
REQ-029 Accept 8'b1010_0100 with out_ready=1 -> beats idx 2, 5, 7 on consecutive cycles; out_last=1 only on 7; in_ready=1 one cycle later.
REQ-030 Accept 8'h80 with out_ready held low for 3 cycles -> idx=7, last=1 stable for all 3 cycles; a single beat on release.
REQ-031 Accept 8'h00 -> no out_valid; empty_pulse high for exactly 1 cycle; in_ready stays 1.
REQ-032 Accept 8'hFF with out_ready toggling 1/0 -> idx 0..7 in order, 8 handshakes, out_last on idx 7; with MASK_ENC_COUNT_EN, out_cnt=8 throughout.
REQ-033 Accept 8'h0F, assert rst_n=0 after the 2nd beat -> out_valid drops immediately; after release, in_ready=1 and no stale beats appear.
REQ-034 in_valid high during SCAN with a different mask -> mask ignored; the current scan completes unchanged.
